// File: rtl/dotmatrix_pkg.sv
// Shared dot-matrix types: column-feed FSM states and matrix geometry.
package dotmatrix_pkg;

  localparam int unsigned MATRIX_COLS = 16;
  localparam int unsigned ROW_W       = 16;
  localparam int unsigned COL_ID_W    = $clog2(MATRIX_COLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LOADC = 2'd2,
    WAIT  = 2'd3
  } scroll_state_e;

endpackage

// File: rtl/scroll_tick_div.sv
// Scroll-step prescaler: one-cycle tick every TICK_DIV enabled cycles; count holds while en=0.
module scroll_tick_div #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en) begin
        if (cnt == LAST) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/column_scroller.sv
// Feeds a 16-column dot matrix from a scrolling message buffer, one column per LOAD strobe.
// Optional COLUMN_SCROLL_REVERSE_EN adds scroll_dir for decrementing scroll.
module column_scroller
  import dotmatrix_pkg::*;
#(
  parameter int unsigned MSG_LEN_LOG2 = 5,
  parameter int unsigned TICK_DIV     = 50000
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    wr_en,
  input  logic [MSG_LEN_LOG2-1:0] wr_addr,
  input  logic [ROW_W-1:0]        wr_data,
  input  logic                    scroll_en,
`ifdef COLUMN_SCROLL_REVERSE_EN
  input  logic                    scroll_dir,
`endif
  input  logic                    ready,
  output logic [ROW_W-1:0]        in_column,
  output logic [COL_ID_W-1:0]     col_id,
  output logic                    LOAD,
  output logic                    frame_done
);

  localparam int unsigned          MSG_LEN  = 2 ** MSG_LEN_LOG2;
  localparam logic [COL_ID_W-1:0]  LAST_COL = COL_ID_W'(MATRIX_COLS - 1);

  logic [ROW_W-1:0]        mem [MSG_LEN];
  logic [MSG_LEN_LOG2-1:0] next_off;
  logic [MSG_LEN_LOG2-1:0] snap_off;
  logic [MSG_LEN_LOG2-1:0] rd_addr;
  logic [COL_ID_W-1:0]     col;
  scroll_state_e           state;
  logic                    tick;
  logic                    dec;

`ifdef COLUMN_SCROLL_REVERSE_EN
  assign dec = scroll_dir;
`else
  assign dec = 1'b0;
`endif

  scroll_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (scroll_en),
    .tick  (tick)
  );

  // Message buffer is not reset; reads in the FSM see pre-write data on a same-address write.
  always_ff @(posedge CLK) begin
    if (wr_en && !RESET) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Scroll offset for the next frame; natural wrap of the address width gives modulo MSG_LEN.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      next_off <= '0;
    end else if (tick) begin
      next_off <= dec ? next_off - MSG_LEN_LOG2'(1) : next_off + MSG_LEN_LOG2'(1);
    end
  end

  assign rd_addr = snap_off + MSG_LEN_LOG2'(col);

  // Column-feed FSM; the frame uses the offset snapshotted in IDLE so mid-frame ticks do not tear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      LOAD       <= 1'b0;
      frame_done <= 1'b0;
      in_column  <= '0;
      col_id     <= '0;
      col        <= '0;
      snap_off   <= '0;
    end else begin
      LOAD       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ready) begin
            snap_off <= next_off;
            col      <= '0;
            state    <= READ;
          end
        end
        READ: begin
          in_column  <= mem[rd_addr];
          col_id     <= col;
          LOAD       <= 1'b1;
          frame_done <= (col == LAST_COL);
          state      <= LOADC;
        end
        LOADC: begin
          if (col == LAST_COL) begin
            state <= IDLE;
          end else begin
            col   <= col + COL_ID_W'(1);
            state <= ready ? READ : WAIT;
          end
        end
        WAIT: begin
          if (ready) begin
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_column_scroller.sv
// Self-checking bench for column_scroller: table of frames plus stall, mid-frame tick and reset sequences.
module tb_column_scroller;

  logic        CLK;
  logic        RESET;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        scroll_en;
  logic        ready;
  logic [15:0] in_column;
  logic [3:0]  col_id;
  logic        LOAD;
  logic        frame_done;
`ifdef COLUMN_SCROLL_REVERSE_EN
  logic        scroll_dir;
`endif

  int n_pass  = 0;
  int n_total = 0;

  column_scroller #(
    .MSG_LEN_LOG2 (5),
    .TICK_DIV     (4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .scroll_en  (scroll_en),
`ifdef COLUMN_SCROLL_REVERSE_EN
    .scroll_dir (scroll_dir),
`endif
    .ready      (ready),
    .in_column  (in_column),
    .col_id     (col_id),
    .LOAD       (LOAD),
    .frame_done (frame_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          scroll_cyc;
    int          off;
    logic [15:0] c0;
    logic [15:0] c15;
    int          stall_col;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Expects one full frame at offset off; optionally drops ready for 10 cycles after stall_col.
  task automatic run_frame(input int off, input logic [15:0] c0, input logic [15:0] c15,
                           input int stall_col);
    int          gap;
    int          idx;
    bit          done;
    logic [15:0] last;
    ready = 1'b1;
    gap   = 0;
    idx   = 0;
    done  = 1'b0;
    last  = '0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge CLK);
      gap++;
      if (LOAD) begin
        chk("load_gap", gap, 2);
        chk("col_id", col_id, idx);
        chk("in_column", in_column, 16'h0100 + 16'((off + idx) % 32));
        chk("frame_done", frame_done, (idx == 15));
        last = in_column;
        if (idx == 0) chk("col0", in_column, c0);
        if (idx == 15) begin
          chk("col15", in_column, c15);
          done  = 1'b1;
          ready = 1'b0;
        end else if (idx == stall_col) begin
          ready = 1'b0;
          for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("stall_quiet", LOAD, 0);
          end
          ready = 1'b1;
        end
        gap = 0;
        idx++;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL frame_timeout: got %0d columns expected 16", idx);
    end
    repeat (2) @(negedge CLK);
    chk("idle_load", LOAD, 0);
    chk("hold_column", in_column, last);
  endtask

  task automatic scroll_cycles(input int n);
    if (n > 0) begin
      scroll_en = 1'b1;
      repeat (n) @(negedge CLK);
      scroll_en = 1'b0;
    end
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    bit found;

    vecs[0] = '{scroll_cyc: 0,  off: 0,  c0: 16'h0100, c15: 16'h010F, stall_col: -1};
    vecs[1] = '{scroll_cyc: 12, off: 3,  c0: 16'h0103, c15: 16'h0112, stall_col: -1};
    vecs[2] = '{scroll_cyc: 68, off: 20, c0: 16'h0114, c15: 16'h0103, stall_col: -1};
    vecs[3] = '{scroll_cyc: 0,  off: 20, c0: 16'h0114, c15: 16'h0103, stall_col: 5};

    RESET     = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    scroll_en = 1'b0;
    ready     = 1'b0;
`ifdef COLUMN_SCROLL_REVERSE_EN
    scroll_dir = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    chk("rst_load", LOAD, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_column", in_column, 0);
    chk("rst_col_id", col_id, 0);
    RESET = 1'b0;

    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_data = 16'h0100 + 16'(i);
    end
    @(negedge CLK);
    wr_en = 1'b0;
    @(negedge CLK);

    for (int v = 0; v < 4; v++) begin
      scroll_cycles(vecs[v].scroll_cyc);
      run_frame(vecs[v].off, vecs[v].c0, vecs[v].c15, vecs[v].stall_col);
    end

    // One tick lands mid-frame: this frame stays at 20, the next moves to 21.
    fork
      run_frame(20, 16'h0114, 16'h0103, -1);
      begin
        repeat (6) @(negedge CLK);
        scroll_en = 1'b1;
        repeat (4) @(negedge CLK);
        scroll_en = 1'b0;
      end
    join
    run_frame(21, 16'h0115, 16'h0104, -1);

    // Reset at column 8 aborts the frame and clears the offset; buffer survives.
    ready = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge CLK);
      if (LOAD && col_id == 4'd8) found = 1'b1;
    end
    if (!found) begin
      n_total++;
      $display("FAIL col8_timeout: got no column 8 expected one");
    end
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_rst_load", LOAD, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_in_column", in_column, 0);
    chk("mid_rst_col_id", col_id, 0);
    RESET = 1'b0;
    ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("post_rst_idle", LOAD, 0);
    run_frame(0, 16'h0100, 16'h010F, -1);

`ifdef COLUMN_SCROLL_REVERSE_EN
    scroll_dir = 1'b1;
    scroll_cycles(4);
    run_frame(31, 16'h011F, 16'h010E, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/column_scroller.md
COLUMN_SCROLLER -- requirements
Module: column_scroller

Interface
REQ-001 Parameter MSG_LEN_LOG2, default 5, message buffer depth is 2**MSG_LEN_LOG2 columns (range 4..8).
REQ-002 Parameter TICK_DIV, default 50000, CLK cycles per scroll step (>=2).
REQ-003 CLK  in  1  sole clock, all logic on rising edge; one clock only.
REQ-004 RESET  in  1  reset, synchronous and active-high.
REQ-005 wr_en  in  1  host write strobe to message buffer.
REQ-006 wr_addr  in  MSG_LEN_LOG2  host write column address.
REQ-007 wr_data  in  16  host write column pattern, bit n = row n.
REQ-008 scroll_en  in  1  enables scroll-step advance.
REQ-009 ready  in  1  downstream matrix can accept a column.
REQ-010 in_column  out  16  column pattern to matrix, valid while LOAD=1.
REQ-011 col_id  out  4  display column index of in_column, valid while LOAD=1.
REQ-012 LOAD  out  1  one-cycle column-valid strobe.
REQ-013 frame_done  out  1  one-cycle pulse after column 15 is loaded.

Function
REQ-014 Buffer SHALL be MSG_LEN x 16 bits, written on wr_en at wr_addr in one cycle; read-first on same-cycle read/write of one address (old data).
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 while scroll_en=1, emitting a one-cycle tick at TICK_DIV-1 then wrapping to 0; scroll_en=0 holds the count.
REQ-016 On tick, next_off SHALL advance +1 modulo MSG_LEN (MSG_LEN-1 wraps to 0).
REQ-017 FSM states: IDLE, READ, LOADC, WAIT.
REQ-018 IDLE: when ready=1, snapshot snap_off<=next_off, col<=0, go READ; else stay.
REQ-019 READ: read buffer at (snap_off+col) mod MSG_LEN, go LOADC next cycle.
REQ-020 LOADC: LOAD=1, in_column=read data, col_id=col for exactly one cycle; if col=15 pulse frame_done same cycle and go IDLE; else col<=col+1 and go READ if ready=1, WAIT if ready=0.
REQ-021 WAIT: go READ when ready=1.
REQ-022 Latency: ready high in IDLE -> first LOAD 2 cycles later; back-to-back columns every 2 cycles with ready held high; full frame 32 cycles.
REQ-023 Ticks during a frame SHALL affect next_off only; displayed frame uses snap_off throughout (no tearing).
REQ-024 Outside LOADC, LOAD=0 and in_column/col_id hold last values.
REQ-025 Host writes during a frame SHALL be visible to any column read after the write cycle.

Reset
REQ-026 RESET=1 at a clock edge SHALL force state IDLE, LOAD=0, frame_done=0, in_column=0, col_id=0, col=0, snap_off=0, next_off=0, prescaler=0, including mid-frame.
REQ-027 Buffer contents SHALL NOT be reset; RESET has priority over wr_en, tick and ready.

Configuration
REQ-028 With COLUMN_SCROLL_REVERSE_EN defined, input scroll_dir (1 bit) SHALL exist; scroll_dir=1 makes tick decrement next_off modulo MSG_LEN (0 wraps to MSG_LEN-1), scroll_dir=0 increments.
REQ-029 Without COLUMN_SCROLL_REVERSE_EN, scroll_dir port SHALL be absent and scrolling is increment-only.

Structure
REQ-030 Shared package dotmatrix_pkg SHALL hold the FSM state enum, MATRIX_COLS=16 and ROW_W=16.
REQ-031 Prescaler SHALL be sub-module scroll_tick_div (CLK, RESET, en, tick; parameter TICK_DIV).

Verification
REQ-032 Reset then write buffer[i]=16'h0100+i for i=0..31, ready=1, scroll_en=0 -> 16 LOAD pulses, col_id 0..15, in_column 16'h0100..16'h010F, frame_done with col_id=15.
REQ-033 TICK_DIV=4, scroll_en=1 for 12 cycles between frames -> next frame starts at 16'h0103, column 15 = 16'h0112.
REQ-034 next_off=20 -> columns 12..15 show buffer[0..3] (16'h0100..16'h0103) via wrap.
REQ-035 ready dropped after col_id=5 for 10 cycles -> no LOAD in that window, col_id=6 follows 2 cycles after ready returns.
REQ-036 Tick mid-frame -> current frame unchanged; next frame offset +1; RESET at col_id=8 -> LOAD=0, next frame begins at col_id=0 with offset 0.
REQ-037 With COLUMN_SCROLL_REVERSE_EN, scroll_dir=1, one tick from offset 0 -> next frame column 0 = 16'h011F.
